// File: rtl/accumulation_ctrl.sv
// ============================================================================
// Module   : accumulation_ctrl
// Purpose  : Job sequencer for the 25-bit subarray accumulator. It clears the
//            accumulator, streams partial sums into it under valid/ready,
//            tracks carry-out overflow and presents the result on valid/ready.
//            Optional macro ACC_CTRL_SAT_EN saturates out_data on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accumulation_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    input  logic [24:0]      in_data,
    output logic             in_ready,
    output logic             acc_en,
    output logic             acc_clr_n,
    output logic [24:0]      acc_data_in,
    input  logic [24:0]      acc_sum,
    input  logic             acc_cout,
    output logic             out_valid,
    output logic [24:0]      out_data,
    output logic             out_ovf,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);
    localparam logic [24:0]      c_sat = 25'h1FF_FFFF;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic             r_ovf;
    logic             r_acc_clr_n;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_fire;
    logic [24:0]      w_result;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = (r_remaining != '0) ? S_RUN : S_OUT;
            end
            S_RUN: begin
                w_in_ready = 1'b1;
                if (in_valid && (r_remaining == c_one)) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_fire = in_valid & w_in_ready;

    // Length is captured only on an accepted start; beats count it down.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_remaining <= len;
        end else if (w_fire) begin
            r_remaining <= r_remaining - c_one;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_ovf <= 1'b0;
        end else if (w_fire && acc_cout) begin
            r_ovf <= 1'b1;
        end
    end

    // Registered from the next state so the pin is low exactly during CLEAR.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_acc_clr_n <= 1'b1;
        end else begin
            r_acc_clr_n <= (w_state_nxt != S_CLEAR);
        end
    end

`ifdef ACC_CTRL_SAT_EN
    assign w_result = r_ovf ? c_sat : acc_sum;
`else
    assign w_result = acc_sum;
`endif

    assign busy        = (r_state != S_IDLE);
    assign in_ready    = w_in_ready;
    assign acc_en      = w_fire;
    assign acc_clr_n   = r_acc_clr_n;
    assign acc_data_in = w_fire ? in_data : 25'd0;
    assign out_valid   = w_out_valid;
    assign out_data    = w_out_valid ? w_result : 25'd0;
    assign out_ovf     = w_out_valid & r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_accumulation_ctrl.sv
// Directed bench for accumulation_ctrl with a behavioural accumulator model
// (enabled DFF plus 25-bit adder with carry-out) on the accumulator pins.
`default_nettype none

module tb_accumulation_ctrl;

    localparam int CNT_W = 8;

    logic             sys_clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic [24:0]      in_data = '0;
    logic             out_ready = 1'b0;

    logic        busy;
    logic        in_ready;
    logic        acc_en;
    logic        acc_clr_n;
    logic [24:0] acc_data_in;
    logic [24:0] acc_sum;
    logic        acc_cout;
    logic        out_valid;
    logic [24:0] out_data;
    logic        out_ovf;

    logic [24:0] acc_reg;
    logic [25:0] acc_add;

`ifdef ACC_CTRL_SAT_EN
    localparam logic [24:0] OVF_EXP = 25'h1FF_FFFF;
`else
    localparam logic [24:0] OVF_EXP = 25'h000_0001;
`endif

    accumulation_ctrl #(.CNT_W(CNT_W)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .acc_en      (acc_en),
        .acc_clr_n   (acc_clr_n),
        .acc_data_in (acc_data_in),
        .acc_sum     (acc_sum),
        .acc_cout    (acc_cout),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ovf     (out_ovf),
        .out_ready   (out_ready)
    );

    // Accumulator model: CLA adder feeding an enable DFF cleared by rst_n.
    assign acc_add  = {1'b0, acc_reg} + {1'b0, acc_data_in};
    assign acc_sum  = acc_reg;
    assign acc_cout = acc_en & acc_add[25];

    always_ff @(posedge sys_clk or negedge acc_clr_n) begin
        if (!acc_clr_n) begin
            acc_reg <= '0;
        end else if (acc_en) begin
            acc_reg <= acc_add[24:0];
        end
    end

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy),        32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),    32'd0);
        chk({tag, "_acc_en"},    32'(acc_en),      32'd0);
        chk({tag, "_clr_n"},     32'(acc_clr_n),   32'd1);
        chk({tag, "_acc_din"},   32'(acc_data_in), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid),   32'd0);
        chk({tag, "_out_data"},  32'(out_data),    32'd0);
        chk({tag, "_out_ovf"},   32'(out_ovf),     32'd0);
    endtask

    // Present one accepted beat in the current RUN cycle, then advance.
    task automatic beat(input string tag, input logic [24:0] d);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        chk({tag, "_acc_en"},  32'(acc_en),      32'd1);
        chk({tag, "_acc_din"}, 32'(acc_data_in), 32'(d));
        step();
    endtask

    task automatic stall(input string tag);
        in_valid = 1'b0;
        in_data  = 25'h123;
        #1;
        chk({tag, "_acc_en"},  32'(acc_en),      32'd0);
        chk({tag, "_acc_din"}, 32'(acc_data_in), 32'd0);
        chk({tag, "_busy"},    32'(busy),        32'd1);
        step();
    endtask

    task automatic launch(input logic [CNT_W-1:0] n);
        start = 1'b1;
        len   = n;
        step();
        start = 1'b0;
        len   = 8'hAA;
    endtask

    initial begin
        // Reset state
        step();
        step();
        idle_outputs("reset");
        rst = 1'b0;
        step();

        // Basic job: len=4, beats 1..4 back-to-back
        launch(8'd4);
        in_valid = 1'b1;
        in_data  = 25'd1;
        #1;
        chk("basic_clear_clr_n",  32'(acc_clr_n), 32'd0);
        chk("basic_clear_ready",  32'(in_ready),  32'd0);
        chk("basic_clear_acc_en", 32'(acc_en),    32'd0);
        chk("basic_clear_busy",   32'(busy),      32'd1);
        step();
        chk("basic_run_clr_n", 32'(acc_clr_n), 32'd1);
        chk("basic_run_ready", 32'(in_ready),  32'd1);
        beat("basic_b1", 25'd1);
        beat("basic_b2", 25'd2);
        beat("basic_b3", 25'd3);
        chk("basic_not_out_yet", 32'(out_valid), 32'd0);
        beat("basic_b4", 25'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("basic_out_valid", 32'(out_valid), 32'd1);
        chk("basic_out_data",  32'(out_data),  32'd10);
        chk("basic_out_ovf",   32'(out_ovf),   32'd0);
        chk("basic_out_ready", 32'(in_ready),  32'd0);
        step();
        out_ready = 1'b0;
        chk("basic_back_idle", 32'(busy), 32'd0);

        // Stalls and backpressure: len=3, beats 5,6,7 with gaps
        launch(8'd3);
        step();
        beat("stall_b1", 25'd5);
        stall("stall_s1");
        beat("stall_b2", 25'd6);
        stall("stall_s2");
        beat("stall_b3", 25'd7);
        in_valid = 1'b1;
        in_data  = 25'd99;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data",  32'(out_data),  32'd18);
            chk("bp_busy",      32'(busy),      32'd1);
            chk("bp_acc_en",    32'(acc_en),    32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_final_data", 32'(out_data), 32'd18);
        step();
        out_ready = 1'b0;
        chk("bp_back_idle", 32'(busy), 32'd0);

        // Overflow: 1FFFFFF + 2 wraps to 1
        launch(8'd2);
        step();
        beat("ovf_b1", 25'h1FF_FFFF);
        in_valid = 1'b1;
        in_data  = 25'd2;
        #1;
        chk("ovf_cout", 32'(acc_cout), 32'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("ovf_out_valid", 32'(out_valid), 32'd1);
        chk("ovf_out_ovf",   32'(out_ovf),   32'd1);
        chk("ovf_out_data",  32'(out_data),  32'(OVF_EXP));
        step();
        out_ready = 1'b0;

        // Zero-length job: OUT two cycles after start, ovf cleared
        launch(8'd0);
        #1;
        chk("zero_clear_clr_n", 32'(acc_clr_n), 32'd0);
        chk("zero_clear_valid", 32'(out_valid), 32'd0);
        step();
        out_ready = 1'b1;
        #1;
        chk("zero_out_valid", 32'(out_valid), 32'd1);
        chk("zero_out_data",  32'(out_data),  32'd0);
        chk("zero_out_ovf",   32'(out_ovf),   32'd0);
        step();
        out_ready = 1'b0;
        chk("zero_back_idle", 32'(busy), 32'd0);

        // Ignored start: pulses during RUN and with the OUT handshake
        launch(8'd2);
        step();
        start = 1'b1;
        len   = 8'd7;
        beat("ign_b1", 25'd10);
        stall("ign_s1");
        start = 1'b0;
        beat("ign_b2", 25'd20);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd3;
        #1;
        chk("ign_out_valid", 32'(out_valid), 32'd1);
        chk("ign_out_data",  32'(out_data),  32'd30);
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("ign_idle_after_out", 32'(busy), 32'd0);
        step();
        chk("ign_still_idle", 32'(busy), 32'd0);

        // Reset mid-job, then a clean len=1 job
        launch(8'd4);
        step();
        beat("rst_b1", 25'd100);
        beat("rst_b2", 25'd200);
        in_valid = 1'b1;
        in_data  = 25'd300;
        rst      = 1'b1;
        #1;
        idle_outputs("midrst");
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        launch(8'd1);
        step();
        beat("post_b1", 25'd9);
        out_ready = 1'b1;
        #1;
        chk("post_out_valid", 32'(out_valid), 32'd1);
        chk("post_out_data",  32'(out_data),  32'd9);
        chk("post_out_ovf",   32'(out_ovf),   32'd0);
        step();
        out_ready = 1'b0;
        chk("post_back_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/accumulation_ctrl.md
# accumulation_ctrl

Job sequencer for the 25-bit subarray accumulator (CLA + enable DFF). It accepts an accumulation job of `len` partial sums and clears the accumulator through its reset pin. It streams the partial sums into the accumulator under a valid/ready handshake, tracks carry-out overflow, and presents the final sum on a valid/ready result port. It sits between the subarray MAC partial-sum source and the downstream result consumer, and drives the accumulator's `sys_en`, `rst_n` and `data_in`.

## Interface
- `CNT_W`, default 8: width of the job length field; max job = 2^CNT_W − 1 beats.
- `sys_clk`, input, 1: system clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: job request; sampled only in IDLE.
- `len`, input, CNT_W: number of partial sums in the job; captured when `start` is sampled.
- `busy`, output, 1: high in every state except IDLE.
- `in_valid`, input, 1: partial sum present.
- `in_data`, input, 25: partial sum, unsigned.
- `in_ready`, output, 1: high only in RUN.
- `acc_en`, output, 1: to accumulator `sys_en`; equals `in_valid & in_ready`.
- `acc_clr_n`, output, 1: to accumulator `rst_n`. Driven directly by a dedicated flop with no decode logic.
- `acc_data_in`, output, 25: to accumulator `data_in`; equals `in_data` when `acc_en`, else 0.
- `acc_sum`, input, 25: accumulator `data_out`.
- `acc_cout`, input, 1: accumulator carry-out.
- `out_valid`, output, 1: result present; high only in OUT.
- `out_data`, output, 25: job result.
- `out_ovf`, output, 1: sticky overflow for the current job.
- `out_ready`, input, 1: consumer accepts result.

## Operation
- **Reset values.** On `rst`: state IDLE, remaining count 0, ovf 0, `acc_clr_n`=1, and all other outputs 0.
- **FSM states:** IDLE, CLEAR, RUN, OUT.
- **IDLE.** On `start`=1, capture `len` into the remaining counter, then go to CLEAR. `start` is ignored in every other state.
- **CLEAR.** Lasts exactly one cycle, with `acc_clr_n`=0 for that cycle and ovf cleared. Next state is RUN if the captured length is nonzero, else OUT.
- **RUN.** `in_ready`=1.
  - Each handshake (`in_valid & in_ready`) asserts `acc_en`, decrements the counter and ORs `acc_cout` into ovf.
  - A handshake with counter==1 moves the FSM to OUT.
  - Cycles with `in_valid`=0 are stalls: nothing changes.
- **OUT.** `out_valid`=1 and `out_data`=`acc_sum`, which is stable because `acc_en`=0. The state holds until `out_ready`=1, then returns to IDLE. A `start` in the same cycle as the `out_ready` handshake is ignored.
- **Width rule.** The sum wraps modulo 2^25. Overflow means `acc_cout`=1 on any enabled beat of the job.
- **Zero-length job.** `len`=0 yields `out_data`=0 and `out_ovf`=0.
- **Reset mid-job.** An asserted `rst` aborts immediately to IDLE with no result emitted. The accumulator contents are left stale; the next job's CLEAR removes them.

## Timing
- `start` sampled at edge T:
  - CLEAR during cycle T+1.
  - `in_ready` first high in cycle T+2.
- With back-to-back `in_valid`, beat k is accepted in cycle T+1+k. `out_valid` rises in cycle T+2+len, so the latency from start to result is len+2 cycles.
- Every stall cycle adds one cycle of latency.
- `out_data` is valid in the first OUT cycle. The accumulator has loaded the last beat on the edge that entered OUT.
- The job-to-job minimum is len+3 cycles, given `out_ready` is held high.
- `acc_en`, `in_ready` and `acc_data_in` are combinational from the state and `in_valid`. `acc_clr_n` is registered.

## Configuration
- **`ACC_CTRL_SAT_EN` defined:** in OUT, if ovf=1 then `out_data`=25'h1FFFFFF; otherwise `out_data`=`acc_sum`. `out_ovf` still reports the overflow.
- **`ACC_CTRL_SAT_EN` undefined:** `out_data`=`acc_sum` always, which is the wrapped value, with `out_ovf` flagging the wrap.

## Test plan
- **Basic job.** `start`, `len`=4, in_data 1,2,3,4 back-to-back, `out_ready`=1 → `acc_clr_n` low for exactly 1 cycle, `out_valid` at T+6, `out_data`=10, `out_ovf`=0, then IDLE.
- **Stalls and backpressure.** `len`=3 with one `in_valid`=0 cycle between each beat (5,6,7); `out_ready` held low for 3 cycles → `out_data`=18 held stable, `out_valid` high until `out_ready`, `busy`=1 throughout.
- **Overflow.** `len`=2, 25'h1FFFFFF then 25'h2 → `out_ovf`=1; `out_data`=25'h000001 without the macro, 25'h1FFFFFF with `ACC_CTRL_SAT_EN`.
- **Zero length and ignored start.** `len`=0 → OUT at T+2 with `out_data`=0. A `start` pulse during RUN of a `len`=2 job has no effect on count or result.
- **Reset mid-job.** `len`=4, assert `rst` after 2 beats → all outputs at reset values asynchronously. A following job with `len`=1 and in_data 9 gives `out_data`=9, with no residue from the aborted job.
